// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types, glyph constants and Morse glyph table
package morse_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_ERR   = 8'hBF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_WAIT_WORD
    } state_e;

    // Counters stick at all-ones so very long presses/gaps never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Index is {symbol count, pattern}; pattern bit i is symbol i (0 = dot, 1 = dash).
    // Glyphs are active-low {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] glyph_lookup(input logic [2:0] count, input logic [4:0] pattern);
        logic [7:0] g;
        case ({count, pattern})
            {3'd1, 5'b00000}: g = 8'h86; // E
            {3'd1, 5'b00001}: g = 8'h87; // T
            {3'd2, 5'b00010}: g = 8'h88; // A
            {3'd2, 5'b00000}: g = 8'hCF; // I
            {3'd2, 5'b00011}: g = 8'hC8; // M
            {3'd2, 5'b00001}: g = 8'hAB; // N
            {3'd3, 5'b00001}: g = 8'hA1; // D
            {3'd3, 5'b00011}: g = 8'hC2; // G
            {3'd3, 5'b00101}: g = 8'h8A; // K
            {3'd3, 5'b00111}: g = 8'hA3; // O
            {3'd3, 5'b00010}: g = 8'hAF; // R
            {3'd3, 5'b00000}: g = 8'h92; // S
            {3'd3, 5'b00100}: g = 8'hC1; // U
            {3'd3, 5'b00110}: g = 8'hD5; // W
            {3'd4, 5'b00001}: g = 8'h83; // B
            {3'd4, 5'b00101}: g = 8'hC6; // C
            {3'd4, 5'b00100}: g = 8'h8E; // F
            {3'd4, 5'b00000}: g = 8'h89; // H
            {3'd4, 5'b01110}: g = 8'hE1; // J
            {3'd4, 5'b00010}: g = 8'hC7; // L
            {3'd4, 5'b00110}: g = 8'h8C; // P
            {3'd4, 5'b01011}: g = 8'h98; // Q
            {3'd4, 5'b01000}: g = 8'hE3; // V
            {3'd4, 5'b01001}: g = 8'h89; // X
            {3'd4, 5'b01101}: g = 8'h91; // Y
            {3'd4, 5'b00011}: g = 8'hA4; // Z
            {3'd5, 5'b11111}: g = 8'hC0; // 0
            {3'd5, 5'b11110}: g = 8'hF9; // 1
            {3'd5, 5'b11100}: g = 8'hA4; // 2
            {3'd5, 5'b11000}: g = 8'hB0; // 3
            {3'd5, 5'b10000}: g = 8'h99; // 4
            {3'd5, 5'b00000}: g = 8'h92; // 5
            {3'd5, 5'b00001}: g = 8'h82; // 6
            {3'd5, 5'b00011}: g = 8'hF8; // 7
            {3'd5, 5'b00111}: g = 8'h80; // 8
            {3'd5, 5'b01111}: g = 8'h90; // 9
            default:          g = GLYPH_ERR;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/morse_symbol_decoder_if.sv
// rtl/morse_symbol_decoder_if.sv - decoded character bus towards the shift buffer
interface morse_symbol_decoder_if;
    logic [7:0] char_out;
    logic       flag;
    logic       bs;
    logic       direction;

    modport master (output char_out, flag, bs, direction);
    modport slave  (input  char_out, flag, bs, direction);
endinterface

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational symbol pattern to seven-segment glyph lookup
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] count,
    input  logic [4:0] pattern,
    output logic [7:0] glyph
);

    // Pure table lookup; unmapped codes fall back to the dash glyph.
    always_comb begin
        glyph = glyph_lookup(count, pattern);
    end

endmodule

// File: rtl/morse_symbol_decoder.sv
// rtl/morse_symbol_decoder.sv - Morse key timing, symbol accumulation and glyph emission
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 200,
    parameter int BS_HOLD    = 1500,
    parameter int LETTER_GAP = 600,
    parameter int WORD_GAP   = 1400,
    parameter int PULSE_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   key,
    morse_symbol_decoder_if.master out_if
);

    localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] DOT_C    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] BS_C     = CNT_W'(BS_HOLD);
    localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP);
    localparam logic [7:0]       PULSE_C  = 8'(PULSE_LEN);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] time_q, time_d;
    logic [4:0]       pattern_q, pattern_d;
    logic [2:0]       sym_q, sym_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       char_q, char_d;
    logic             dir_q, dir_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    logic             pulse_bs_q, pulse_bs_d;

    logic [CNT_W-1:0] time_inc;
    logic [7:0]       lut_glyph;
    logic             start_flag, start_bs;

    morse_lut u_lut (
        .count   (sym_q),
        .pattern (pattern_q),
        .glyph   (lut_glyph)
    );

    // Synchronize the raw key and accept a new level only after DEBOUNCE differing ticks.
    always_comb begin
        sync_d   = {sync_q[0], key};
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (sync_q[1] == db_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q >= DEB_C - CNT_W'(1)) begin
                db_d     = sync_q[1];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        rise = db_d & ~db_q;
        fall = ~db_d & db_q;
    end

    // Press/gap timing FSM plus glyph/backspace emission and pulse stretching.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        pattern_d   = pattern_q;
        sym_d       = sym_q;
        ovf_d       = ovf_q;
        char_d      = char_q;
        dir_d       = dir_q;
        pulse_bs_d  = pulse_bs_q;
        pulse_cnt_d = (pulse_cnt_q != 8'd0) ? pulse_cnt_q - 8'd1 : 8'd0;
        start_flag  = 1'b0;
        start_bs    = 1'b0;
        time_inc    = tick ? sat_inc(time_q) : time_q;

        // Edges are evaluated against the count before this tick's increment.
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS;
                    time_d  = '0;
                end
            end
            S_PRESS: begin
                if (fall) begin
                    if (time_q >= BS_C) begin
                        start_bs  = 1'b1;
                        pattern_d = '0;
                        sym_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        if (sym_q < 3'd5) begin
                            pattern_d[sym_q] = (time_q >= DOT_C);
                            sym_d            = sym_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = S_GAP;
                        time_d  = '0;
                    end
                end else begin
                    time_d = time_inc;
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_PRESS;
                    time_d  = '0;
                end else if (time_q >= LETTER_C) begin
                    char_d     = ovf_q ? GLYPH_ERR : lut_glyph;
                    start_flag = 1'b1;
                    pattern_d  = '0;
                    sym_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = S_WAIT_WORD;
                    time_d     = time_inc;
                end else begin
                    time_d = time_inc;
                end
            end
            S_WAIT_WORD: begin
                if (rise) begin
                    state_d = S_PRESS;
                    time_d  = '0;
                end else if (time_q >= WORD_C) begin
                    char_d     = GLYPH_BLANK;
                    start_flag = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    time_d = time_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_flag) begin
            pulse_cnt_d = PULSE_C;
            pulse_bs_d  = 1'b0;
            dir_d       = 1'b0;
        end else if (start_bs) begin
            pulse_cnt_d = PULSE_C;
            pulse_bs_d  = 1'b1;
            dir_d       = 1'b1;
        end
    end

    // State registers; reset drops any partial letter and active pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= S_IDLE;
            time_q      <= '0;
            pattern_q   <= '0;
            sym_q       <= '0;
            ovf_q       <= 1'b0;
            char_q      <= GLYPH_BLANK;
            dir_q       <= 1'b0;
            pulse_cnt_q <= '0;
            pulse_bs_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            time_q      <= time_d;
            pattern_q   <= pattern_d;
            sym_q       <= sym_d;
            ovf_q       <= ovf_d;
            char_q      <= char_d;
            dir_q       <= dir_d;
            pulse_cnt_q <= pulse_cnt_d;
            pulse_bs_q  <= pulse_bs_d;
        end
    end

    // One shared stretcher, so flag and bs can never be high together.
    always_comb begin
        out_if.char_out  = char_q;
        out_if.direction = dir_q;
        out_if.flag      = (pulse_cnt_q != 8'd0) && !pulse_bs_q;
        out_if.bs        = (pulse_cnt_q != 8'd0) && pulse_bs_q;
    end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb/tb_morse_symbol_decoder.sv - scoreboard bench for morse_symbol_decoder
module tb_morse_symbol_decoder;

    typedef struct {
        logic       is_bs;
        logic [7:0] ch;
        logic       dir;
        string      tag;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;
    logic key  = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    morse_symbol_decoder_if dec_if ();

    morse_symbol_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .key    (key),
        .out_if (dec_if)
    );

    always #5 clk = ~clk;

    int unsigned tick_div = 0;
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        tick     = (tick_div == 0);
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic press(input int n);
        @(negedge clk);
        key = 1'b1;
        wait_ticks(n);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        key = 1'b0;
        wait_ticks(n);
    endtask

    task automatic expect_evt(input logic is_bs, input logic [7:0] ch, input logic dir, input string tag);
        exp_t e;
        e.is_bs = is_bs;
        e.ch    = ch;
        e.dir   = dir;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic drained(input string tag);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drained_%s: pending=%0d expected=0", tag, sb.size());
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] ch, input logic fl, input logic b, input logic dir);
        checks++;
        assert (dec_if.char_out === ch) else begin
            failures++;
            $error("FAIL %s_char: got %h expected %h", tag, dec_if.char_out, ch);
        end
        checks++;
        assert (dec_if.flag === fl) else begin
            failures++;
            $error("FAIL %s_flag: got %b expected %b", tag, dec_if.flag, fl);
        end
        checks++;
        assert (dec_if.bs === b) else begin
            failures++;
            $error("FAIL %s_bs: got %b expected %b", tag, dec_if.bs, b);
        end
        checks++;
        assert (dec_if.direction === dir) else begin
            failures++;
            $error("FAIL %s_dir: got %b expected %b", tag, dec_if.direction, dir);
        end
    endtask

    logic       prev_flag = 1'b0;
    logic       prev_bs   = 1'b0;
    logic       active    = 1'b0;
    int         width     = 0;
    int         overlap   = 0;
    int         hold_left = 0;
    logic       unstable  = 1'b0;
    logic [7:0] held_ch;
    logic       held_dir;
    string      cur_tag   = "none";

    // Monitor: pop the scoreboard on every pulse rise, then check width and output stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_flag = 1'b0;
            prev_bs   = 1'b0;
            active    = 1'b0;
            hold_left = 0;
        end else begin
            if ((dec_if.flag && !prev_flag) || (dec_if.bs && !prev_bs)) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_event: got char=%h bs=%b expected no event", dec_if.char_out, dec_if.bs);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    cur_tag = e.tag;
                    checks++;
                    assert (dec_if.bs === e.is_bs) else begin
                        failures++;
                        $error("FAIL %s_kind: got bs=%b expected bs=%b", e.tag, dec_if.bs, e.is_bs);
                    end
                    checks++;
                    assert (dec_if.char_out === e.ch) else begin
                        failures++;
                        $error("FAIL %s_char: got %h expected %h", e.tag, dec_if.char_out, e.ch);
                    end
                    checks++;
                    assert (dec_if.direction === e.dir) else begin
                        failures++;
                        $error("FAIL %s_dir: got %b expected %b", e.tag, dec_if.direction, e.dir);
                    end
                end
                active    = 1'b1;
                width     = 0;
                overlap   = 0;
                hold_left = 6;
                unstable  = 1'b0;
                held_ch   = dec_if.char_out;
                held_dir  = dec_if.direction;
            end
            if (hold_left > 0) begin
                if (dec_if.char_out !== held_ch || dec_if.direction !== held_dir) unstable = 1'b1;
                hold_left--;
                if (hold_left == 0) begin
                    checks++;
                    assert (unstable === 1'b0) else begin
                        failures++;
                        $error("FAIL %s_stable: got changed expected held for 6 cycles", cur_tag);
                    end
                end
            end
            if (active) begin
                if (dec_if.flag || dec_if.bs) begin
                    width++;
                    if (dec_if.flag && dec_if.bs) overlap++;
                end else begin
                    active = 1'b0;
                    checks++;
                    assert (width == 4) else begin
                        failures++;
                        $error("FAIL %s_width: got %0d expected 4", cur_tag, width);
                    end
                    checks++;
                    assert (overlap == 0) else begin
                        failures++;
                        $error("FAIL %s_overlap: got %0d expected 0", cur_tag, overlap);
                    end
                end
            end
            prev_flag = dec_if.flag;
            prev_bs   = dec_if.bs;
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check_out("reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_ticks(20);

        // 'E': single dot
        expect_evt(1'b0, 8'h86, 1'b0, "E");
        press(50);
        gap(700);
        drained("E");

        // Reset in the middle of a press: outputs back to reset, partial letter lost
        press(100);
        @(negedge clk);
        rst = 1'b1;
        key = 1'b0;
        @(negedge clk);
        check_out("rst_mid", 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(1600);
        drained("rst_quiet");

        // 'A' then a word gap producing a blank
        expect_evt(1'b0, 8'h88, 1'b0, "A");
        press(50);
        gap(100);
        press(300);
        gap(700);
        drained("A");
        expect_evt(1'b0, 8'hFF, 1'b0, "blank");
        wait_ticks(1400);
        drained("blank");

        // Six dots overflow the 5-symbol buffer
        expect_evt(1'b0, 8'hBF, 1'b0, "ovf");
        for (int i = 0; i < 6; i++) begin
            press(50);
            if (i < 5) gap(100);
        end
        gap(700);
        drained("ovf");

        // Long hold: backspace, char_out keeps the last glyph (0xBF)
        expect_evt(1'b1, 8'hBF, 1'b1, "bs");
        press(1600);
        gap(100);
        drained("bs");

        // 'T' after backspace returns direction to insert
        expect_evt(1'b0, 8'h87, 1'b0, "T");
        press(300);
        gap(700);
        drained("T");

        // 'I' with 3-tick chatter inside both gaps
        expect_evt(1'b0, 8'hCF, 1'b0, "chatter");
        press(50);
        gap(40);
        press(3);
        gap(57);
        press(50);
        gap(200);
        press(3);
        gap(497);
        drained("chatter");

        wait_ticks(50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
